spi_master: RTL and testbench

- SPI bus initiator: drives NSS, SCK and MOSI, and samples MISO for a single fixed-length word per frame.
- Exercises the board's 16-bit SPI control/status slave from inside the iCE40, and serves as the bench driver for that slave in FPGA-side tests.
- Sits in the MCLK-derived system clock domain.
- Shift logic runs on clk_i with enable strobes; SCK is a registered output, not a clock.

---
 rtl/spi_master.sv | 174 +++++++++++++++++
 tb/tb_spi_master.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI bus initiator: one fixed-length word per frame, MSB first.
// SCK, NSS and MOSI are registered outputs driven from clk_i; MISO is
// sampled on the same clk_i edge that moves SCK.
module spi_master #(
  parameter int unsigned IO_COUNT   = 16,
  parameter int unsigned CPOL       = 0,
  parameter int unsigned CPHA       = 0,
  parameter int unsigned HALF_DIV   = 4,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [IO_COUNT-1:0] data_i,
  output logic [IO_COUNT-1:0] data_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                nss_o,
  output logic                sck_o,
  output logic                sdo_o,
  input  logic                sdi_i
);

  localparam int unsigned HW = $clog2(HALF_DIV + 1);
  localparam int unsigned EW = $clog2(2 * IO_COUNT + 1);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_XFER,
    S_LAG,
    S_GAP
  } state_t;

  state_t              r_state;
  logic [HW-1:0]       r_hcnt;
  logic [EW-1:0]       r_ecnt;
  logic [GW-1:0]       r_gcnt;
  logic [IO_COUNT-1:0] r_tx;
  logic [IO_COUNT-1:0] r_rx;
  logic [IO_COUNT-1:0] r_data;
  logic                r_busy;
  logic                r_done;
  logic                r_nss;
  logic                r_sck;
  logic                r_sdo;

  logic w_cpol;
  logic w_cpha;
  logic w_half_end;
  logic w_lead_edge;
  logic w_last_edge;

  assign w_cpol      = (CPOL != 0);
  assign w_cpha      = (CPHA != 0);
  // Last clk_i cycle of a half SCK period; an SCK edge happens on it in XFER.
  assign w_half_end  = (r_hcnt == HW'(HALF_DIV - 1));
  // Edges already issued even -> the upcoming edge is a leading one.
  assign w_lead_edge = ~r_ecnt[0];
  assign w_last_edge = (r_ecnt == EW'(2 * IO_COUNT - 1));

  // Frame sequencer, shift registers and all registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_hcnt  <= '0;
      r_ecnt  <= '0;
      r_gcnt  <= '0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_nss   <= 1'b1;
      r_sck   <= w_cpol;
      r_sdo   <= 1'b0;
      // An aborted frame leaves the last received word visible.
      if (r_state != S_IDLE) begin
        r_data <= r_data;
      end else begin
        r_data <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_tx    <= data_i;
            r_hcnt  <= '0;
            r_state <= S_LEAD;
          end
        end

        // First cycle here only lowers NSS; the HALF_DIV cycles after it
        // are the select-to-clock lead time.
        S_LEAD: begin
          r_nss  <= 1'b0;
          r_busy <= 1'b1;
          if (!w_cpha) begin
            r_sdo <= r_tx[IO_COUNT-1];
          end
          if (r_hcnt == HW'(HALF_DIV)) begin
            r_hcnt  <= '0;
            r_ecnt  <= '0;
            r_state <= S_XFER;
          end else begin
            r_hcnt <= r_hcnt + HW'(1);
          end
        end

        S_XFER: begin
          if (w_half_end) begin
            r_hcnt <= '0;
            r_sck  <= ~r_sck;
            r_ecnt <= r_ecnt + EW'(1);
            if (w_lead_edge) begin
              if (!w_cpha) begin
                r_rx <= {r_rx[IO_COUNT-2:0], sdi_i};
              end else begin
                r_sdo <= r_tx[IO_COUNT-1];
                r_tx  <= {r_tx[IO_COUNT-2:0], 1'b0};
              end
            end else begin
              if (w_cpha) begin
                r_rx <= {r_rx[IO_COUNT-2:0], sdi_i};
              end else if (!w_last_edge) begin
                r_sdo <= r_tx[IO_COUNT-2];
                r_tx  <= {r_tx[IO_COUNT-2:0], 1'b0};
              end
            end
            if (w_last_edge) begin
              r_state <= S_LAG;
            end
          end else begin
            r_hcnt <= r_hcnt + HW'(1);
          end
        end

        S_LAG: begin
          if (w_half_end) begin
            r_hcnt  <= '0;
            r_nss   <= 1'b1;
            r_data  <= r_rx;
            r_done  <= 1'b1;
            r_gcnt  <= '0;
            r_state <= S_GAP;
          end else begin
            r_hcnt <= r_hcnt + HW'(1);
          end
        end

        S_GAP: begin
          if (r_gcnt == GW'(GAP_CYCLES - 1)) begin
            r_gcnt  <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_gcnt <= r_gcnt + GW'(1);
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data_o = r_data;
  assign busy_o = r_busy;
  assign done_o = r_done;
  assign nss_o  = r_nss;
  assign sck_o  = r_sck;
  assign sdo_o  = r_sdo;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: three configurations (mode 0 / HALF_DIV 4,
// mode 3 / HALF_DIV 1, 8-bit / HALF_DIV 2 / GAP 1) against a behavioural
// SPI slave and frame-timing arithmetic.
module tb_spi_master;

  int n_checks = 0;
  int n_fail   = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: IO 16, CPOL 0, CPHA 0, HALF_DIV 4, GAP 2
  logic        start_a;
  logic [15:0] din_a, dout_a;
  logic        busy_a, done_a, nss_a, sck_a, sdo_a, sdi_a;
  logic        lb_a, slv_bit;
  assign sdi_a = lb_a ? sdo_a : slv_bit;

  // Instance B: IO 16, CPOL 1, CPHA 1, HALF_DIV 1, GAP 2, loopback
  logic        start_b;
  logic [15:0] din_b, dout_b;
  logic        busy_b, done_b, nss_b, sck_b, sdo_b;

  // Instance C: IO 8, CPOL 0, CPHA 0, HALF_DIV 2, GAP 1, loopback
  logic        start_c;
  logic [7:0]  din_c, dout_c;
  logic        busy_c, done_c, nss_c, sck_c, sdo_c;

  spi_master #(.IO_COUNT(16), .CPOL(0), .CPHA(0), .HALF_DIV(4), .GAP_CYCLES(2)) u_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .data_i(din_a), .data_o(dout_a),
    .busy_o(busy_a), .done_o(done_a), .nss_o(nss_a), .sck_o(sck_a), .sdo_o(sdo_a),
    .sdi_i(sdi_a));

  spi_master #(.IO_COUNT(16), .CPOL(1), .CPHA(1), .HALF_DIV(1), .GAP_CYCLES(2)) u_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .data_i(din_b), .data_o(dout_b),
    .busy_o(busy_b), .done_o(done_b), .nss_o(nss_b), .sck_o(sck_b), .sdo_o(sdo_b),
    .sdi_i(sdo_b));

  spi_master #(.IO_COUNT(8), .CPOL(0), .CPHA(0), .HALF_DIV(2), .GAP_CYCLES(1)) u_c (
    .clk_i(clk), .rst_i(rst), .start_i(start_c), .data_i(din_c), .data_o(dout_c),
    .busy_o(busy_c), .done_o(done_c), .nss_o(nss_c), .sck_o(sck_c), .sdo_o(sdo_c),
    .sdi_i(sdo_c));

  // Reference timing: NSS-low length of one frame.
  function automatic int frame_len(input int io, input int hd);
    return (2 * io + 2) * hd;
  endfunction

  // One frame on A. Acts as a mode-0 slave returning slv (or loops MOSI
  // back) and measures the frame. lat = clk edges from accept to done.
  task automatic run_a(input logic [15:0] tx, input logic [15:0] slv, input bit loop,
                       output int nss_low, output int rises, output int falls,
                       output int dones, output int lat, output logic [15:0] cap,
                       output int unstable, output bit timeout);
    logic pn, ps, psdo;
    logic [15:0] sh;
    int kd;
    nss_low = 0; rises = 0; falls = 0; dones = 0; lat = -1; unstable = 0;
    cap = '0; timeout = 1'b1; kd = -1; sh = slv;
    lb_a = loop; slv_bit = 1'b0;
    repeat (2) @(negedge clk);
    din_a = tx; start_a = 1'b1;
    pn = nss_a; ps = sck_a; psdo = sdo_a;
    for (int k = 1; k <= 3000; k++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (!nss_a) nss_low++;
      if (pn && !nss_a) slv_bit = sh[15];
      if (!ps && sck_a) begin
        rises++;
        cap = {cap[14:0], sdo_a};
        if (sdo_a !== psdo) unstable++;
      end
      if (ps && !sck_a) begin
        falls++;
        sh = {sh[14:0], 1'b0};
        slv_bit = sh[15];
      end
      if (done_a === 1'b1) begin
        dones++;
        if (kd < 0) begin kd = k; lat = k - 1; end
      end
      if (kd >= 0 && k >= kd + 4) begin timeout = 1'b0; break; end
      pn = nss_a; ps = sck_a; psdo = sdo_a;
    end
  endtask

  // One loopback frame on B; drv collects MOSI after each falling (leading) edge.
  task automatic run_b(input logic [15:0] tx, output int nss_low, output int rises,
                       output int falls, output int lat, output logic [15:0] drv,
                       output int idle_bad, output bit timeout);
    logic ps;
    int kd;
    nss_low = 0; rises = 0; falls = 0; lat = -1; drv = '0; idle_bad = 0;
    timeout = 1'b1; kd = -1;
    repeat (2) @(negedge clk);
    din_b = tx; start_b = 1'b1;
    ps = sck_b;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge clk);
      start_b = 1'b0;
      if (!nss_b) nss_low++;
      if (nss_b && sck_b !== 1'b1) idle_bad++;
      if (!ps && sck_b) rises++;
      if (ps && !sck_b) begin
        falls++;
        drv = {drv[14:0], sdo_b};
      end
      if (done_b === 1'b1 && kd < 0) begin kd = k; lat = k - 1; end
      if (kd >= 0 && k >= kd + 4) begin timeout = 1'b0; break; end
      ps = sck_b;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (nss_a !== 1'b1) begin n_fail++; $display("FAIL reset_nss_a got %b want 1", nss_a); end
    n_checks++; if (sck_a !== 1'b0) begin n_fail++; $display("FAIL reset_sck_a got %b want 0", sck_a); end
    n_checks++; if (sdo_a !== 1'b0) begin n_fail++; $display("FAIL reset_sdo_a got %b want 0", sdo_a); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy_a got %b want 0", busy_a); end
    n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done_a got %b want 0", done_a); end
    n_checks++; if (dout_a !== 16'h0) begin n_fail++; $display("FAIL reset_data_a got %h want 0000", dout_a); end
    n_checks++; if (sck_b !== 1'b1) begin n_fail++; $display("FAIL reset_sck_b got %b want 1", sck_b); end
    n_checks++; if (nss_b !== 1'b1) begin n_fail++; $display("FAIL reset_nss_b got %b want 1", nss_b); end
    n_checks++; if (dout_c !== 8'h0) begin n_fail++; $display("FAIL reset_data_c got %h want 00", dout_c); end
    rst = 1'b0;
  endtask

  task automatic test_loopback_mode0();
    int nl, r, f, d, lat, un; logic [15:0] cap; bit to;
    run_a(16'hA5C3, 16'h0, 1'b1, nl, r, f, d, lat, cap, un, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL lb0_timeout got no done want done"); end
    n_checks++; if (r != 16) begin n_fail++; $display("FAIL lb0_rises got %0d want 16", r); end
    n_checks++; if (f != 16) begin n_fail++; $display("FAIL lb0_falls got %0d want 16", f); end
    n_checks++; if (nl != frame_len(16, 4)) begin n_fail++; $display("FAIL lb0_nss_low got %0d want %0d", nl, frame_len(16, 4)); end
    n_checks++; if (d != 1) begin n_fail++; $display("FAIL lb0_done_pulses got %0d want 1", d); end
    n_checks++; if (lat != frame_len(16, 4) + 1) begin n_fail++; $display("FAIL lb0_latency got %0d want %0d", lat, frame_len(16, 4) + 1); end
    n_checks++; if (dout_a !== 16'hA5C3) begin n_fail++; $display("FAIL lb0_data got %h want a5c3", dout_a); end
    n_checks++; if (cap !== 16'hA5C3) begin n_fail++; $display("FAIL lb0_mosi got %h want a5c3", cap); end
  endtask

  task automatic test_slave_mode0();
    int nl, r, f, d, lat, un; logic [15:0] cap, tx, slv; bit to;
    run_a(16'h8001, 16'h01FF, 1'b0, nl, r, f, d, lat, cap, un, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL slv_timeout got no done want done"); end
    n_checks++; if (cap !== 16'h8001) begin n_fail++; $display("FAIL slv_capture got %h want 8001", cap); end
    n_checks++; if (dout_a !== 16'h01FF) begin n_fail++; $display("FAIL slv_data got %h want 01ff", dout_a); end
    n_checks++; if (un != 0) begin n_fail++; $display("FAIL slv_sdo_stable got %0d changes want 0", un); end
    for (int i = 0; i < 4; i++) begin
      tx = 16'($urandom); slv = 16'($urandom);
      run_a(tx, slv, 1'b0, nl, r, f, d, lat, cap, un, to);
      n_checks++; if (to || dout_a !== slv) begin n_fail++; $display("FAIL slv_rand_data got %h want %h", dout_a, slv); end
      n_checks++; if (cap !== tx) begin n_fail++; $display("FAIL slv_rand_capture got %h want %h", cap, tx); end
      n_checks++; if (un != 0 || d != 1) begin n_fail++; $display("FAIL slv_rand_shape got unstable=%0d dones=%0d want 0/1", un, d); end
    end
  endtask

  task automatic test_mode3();
    int nl, r, f, lat, ib; logic [15:0] drv, tx; bit to;
    tx = 16'h3C5A;
    run_b(tx, nl, r, f, lat, drv, ib, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL m3_timeout got no done want done"); end
    n_checks++; if (ib != 0) begin n_fail++; $display("FAIL m3_idle_high got %0d low samples want 0", ib); end
    n_checks++; if (drv[15] !== tx[15]) begin n_fail++; $display("FAIL m3_first_bit got %b want %b", drv[15], tx[15]); end
    n_checks++; if (drv !== tx) begin n_fail++; $display("FAIL m3_mosi got %h want %h", drv, tx); end
    n_checks++; if (dout_b !== tx) begin n_fail++; $display("FAIL m3_data got %h want %h", dout_b, tx); end
    n_checks++; if (lat != frame_len(16, 1) + 1) begin n_fail++; $display("FAIL m3_latency got %0d want %0d", lat, frame_len(16, 1) + 1); end
    n_checks++; if (nl != frame_len(16, 1) || r != 16 || f != 16) begin n_fail++; $display("FAIL m3_shape got nss=%0d r=%0d f=%0d want %0d/16/16", nl, r, f, frame_len(16, 1)); end
    for (int i = 0; i < 3; i++) begin
      tx = 16'($urandom);
      run_b(tx, nl, r, f, lat, drv, ib, to);
      n_checks++; if (to || dout_b !== tx || drv !== tx) begin n_fail++; $display("FAIL m3_rand got data=%h mosi=%h want %h", dout_b, drv, tx); end
    end
  endtask

  // A with start held high: one frame, then the next only after the gap.
  task automatic test_back_to_back();
    logic pn, pb; bit bseen, to;
    int nf, fd, r1, f2, bl, bdrop, nl1, fat;
    logic [15:0] tx;
    nf = 0; fd = -1; r1 = -1; f2 = -1; bl = 0; bdrop = 0; nl1 = 0; fat = -1;
    bseen = 1'b0; to = 1'b1;
    tx = 16'($urandom); lb_a = 1'b1;
    repeat (2) @(negedge clk);
    din_a = tx; start_a = 1'b1;
    pn = nss_a; pb = busy_a;
    for (int k = 1; k <= 800; k++) begin
      @(negedge clk);
      if (pn && !nss_a) begin
        nf++;
        if (nf == 2) begin f2 = k; start_a = 1'b0; end
      end
      if (!pn && nss_a && r1 < 0) r1 = k;
      if (nf == 1 && !nss_a) nl1++;
      if (busy_a) bseen = 1'b1;
      if (bseen && fd < 0 && pb && !busy_a) bdrop++;
      if (fd >= 0 && f2 < 0 && !busy_a) bl++;
      if (done_a === 1'b1) begin
        if (fd < 0) begin fd = k; fat = nf; end
        else if (f2 >= 0) begin to = 1'b0; break; end
      end
      pn = nss_a; pb = busy_a;
    end
    start_a = 1'b0;
    n_checks++; if (to) begin n_fail++; $display("FAIL b2b_timeout got no second done want done"); end
    n_checks++; if (fat != 1) begin n_fail++; $display("FAIL b2b_single_frame got %0d nss falls want 1", fat); end
    n_checks++; if (nl1 != frame_len(16, 4)) begin n_fail++; $display("FAIL b2b_nss_low got %0d want %0d", nl1, frame_len(16, 4)); end
    n_checks++; if (f2 - r1 != 2 + 2) begin n_fail++; $display("FAIL b2b_nss_gap got %0d want 4", f2 - r1); end
    n_checks++; if (bdrop != 0) begin n_fail++; $display("FAIL b2b_busy_contig got %0d drops want 0", bdrop); end
    n_checks++; if (bl != 2) begin n_fail++; $display("FAIL b2b_busy_low got %0d want 2", bl); end
    n_checks++; if (dout_a !== tx) begin n_fail++; $display("FAIL b2b_data got %h want %h", dout_a, tx); end
    repeat (8) @(negedge clk);
  endtask

  // C with start held high: done-to-done period and data every frame.
  task automatic test_held_start_c();
    int t[4]; logic [7:0] d[4]; int nd; int per;
    bit to;
    nd = 0; to = 1'b1;
    per = frame_len(8, 2) + 1 + 2;
    @(negedge clk);
    din_c = 8'h96; start_c = 1'b1;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge clk);
      if (done_c === 1'b1) begin
        t[nd] = k; d[nd] = dout_c; nd++;
        if (nd == 4) begin to = 1'b0; break; end
      end
    end
    start_c = 1'b0;
    n_checks++; if (to) begin n_fail++; $display("FAIL held_timeout got %0d dones want 4", nd); end
    if (!to) begin
      for (int i = 1; i < 4; i++) begin
        n_checks++; if (t[i] - t[i-1] != per) begin n_fail++; $display("FAIL held_period%0d got %0d want %0d", i, t[i] - t[i-1], per); end
      end
      for (int i = 0; i < 4; i++) begin
        n_checks++; if (d[i] !== 8'h96) begin n_fail++; $display("FAIL held_data%0d got %h want 96", i, d[i]); end
      end
    end
    repeat (10) @(negedge clk);
  endtask

  // Reset on A at the 7th SCK edge: abort, keep last word, then recover.
  task automatic test_reset_mid_frame();
    int nl, r, f, dn, lat, un, edges, dseen; logic [15:0] cap, tx; logic ps; bit to;
    run_a(16'h1234, 16'h0, 1'b1, nl, r, f, dn, lat, cap, un, to);
    n_checks++; if (to || dout_a !== 16'h1234) begin n_fail++; $display("FAIL rstm_pre got %h want 1234", dout_a); end
    repeat (2) @(negedge clk);
    din_a = 16'($urandom); start_a = 1'b1;
    ps = sck_a; edges = 0;
    for (int k = 0; k < 500 && edges < 6; k++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (sck_a !== ps) edges++;
      ps = sck_a;
    end
    n_checks++; if (edges != 6) begin n_fail++; $display("FAIL rstm_edges got %0d want 6", edges); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (nss_a !== 1'b1) begin n_fail++; $display("FAIL rstm_nss got %b want 1", nss_a); end
    n_checks++; if (sck_a !== 1'b0) begin n_fail++; $display("FAIL rstm_sck got %b want 0", sck_a); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rstm_busy got %b want 0", busy_a); end
    n_checks++; if (dout_a !== 16'h1234) begin n_fail++; $display("FAIL rstm_data got %h want 1234", dout_a); end
    dseen = (done_a === 1'b1) ? 1 : 0;
    repeat (6) begin
      @(negedge clk);
      if (done_a === 1'b1 || busy_a === 1'b1) dseen++;
    end
    n_checks++; if (dseen != 0) begin n_fail++; $display("FAIL rstm_no_done got %0d done/busy samples want 0", dseen); end
    tx = 16'($urandom);
    run_a(tx, 16'h0, 1'b1, nl, r, f, dn, lat, cap, un, to);
    n_checks++; if (to || dout_a !== tx || dn != 1) begin n_fail++; $display("FAIL rstm_recover got %h dones=%0d want %h/1", dout_a, dn, tx); end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog got time limit want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    din_a = '0; din_b = '0; din_c = '0;
    lb_a = 1'b1; slv_bit = 1'b0;
    test_reset();
    test_loopback_mode0();
    test_slave_mode0();
    test_mode3();
    test_back_to_back();
    test_held_start_c();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
